glb_ld_dma_addr_gen: RTL
========================

Name: glb_ld_dma_addr_gen

Overview:
Multi-entry load-DMA address generator for one GLB tile. It holds a queue of QUEUE_DEPTH load headers, each with LOOP_LEVEL nested range/stride loops and an optional active/inactive duty cycle. It emits a stream of read requests (rd_en/rd_addr, valid/ready) towards the bank read-request path. It generalises the fixed-depth load header to a configurable loop depth, a header queue, and the OFF/NORMAL/REPEAT/AUTO_INCR modes.

Parameters:
LOOP_LEVEL, 4, number of nested loops per header (level 0 innermost)
QUEUE_DEPTH, 4, header queue entries (power of 2, >=2)
GLB_ADDR_WIDTH, 22, byte address width
MAX_NUM_WORDS_WIDTH, 16, width of range, num_active_words and num_inactive_words
MAX_STRIDE_WIDTH, 16, stride width (unsigned bytes)
HDR_WIDTH, derived, 1+GLB_ADDR_WIDTH+LOOP_LEVEL*(MAX_NUM_WORDS_WIDTH+MAX_STRIDE_WIDTH)+2*MAX_NUM_WORDS_WIDTH

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
mode  in  2  OFF=0, NORMAL=1, REPEAT=2, AUTO_INCR=3
start  in  1  single-cycle start pulse
hdr_wr_en  in  1  header queue write strobe
hdr_wr_idx  in  $clog2(QUEUE_DEPTH)  header entry index
hdr_wr_data  in  HDR_WIDTH  packed load header {valid,start_addr,iteration[LOOP_LEVEL-1:0],num_active_words,num_inactive_words}
rd_ready  in  1  downstream accepts request
rd_en  out  1  read request valid
rd_addr  out  GLB_ADDR_WIDTH  read byte address
busy  out  1  not IDLE
done  out  1  one-cycle pulse at end of run
cur_entry  out  $clog2(QUEUE_DEPTH)  entry being or last processed

Behaviour:
- Reset: all outputs 0, queue valid bits 0, entry pointer 0, state IDLE. Reset mid-run aborts immediately with no done pulse.
- Queue writes are accepted in any state. The active entry is copied into working registers at load, so rewriting it mid-run has no effect on the current run.
- States: IDLE, LOAD, ACTIVE, GAP, NEXT.
- IDLE: start with mode!=OFF -> LOAD. In NORMAL/REPEAT the pointer is reset to 0; in AUTO_INCR the current pointer is kept. start while busy is ignored. mode=OFF makes start a no-op.
- LOAD (1 cycle): if the entry is invalid or any range is 0 -> NEXT with no requests. Otherwise latch the header, clear the loop iterators, set addr=start_addr, -> ACTIVE.
- ACTIVE: rd_en=1, rd_addr=current addr.
  - On rd_en&&rd_ready, advance level 0. On wrap, the level resets to 0, its accumulated offset clears, and the carry goes to the next level.
  - addr = start_addr + sum(itr_i*stride_i), computed incrementally with adders only (no multipliers), modulo 2^GLB_ADDR_WIDTH.
  - rd_en and rd_addr hold stable while rd_ready=0.
- Duty cycle: count accepted words. When the count reaches num_active_words (nonzero) and num_inactive_words!=0 -> GAP for exactly num_inactive_words cycles with rd_en=0, then back to ACTIVE with the count cleared. num_active_words=0 disables the duty cycle.
- Completion: the accept that wraps the outermost level -> NEXT; this takes priority over entering GAP.
- NEXT (1 cycle):
  - NORMAL: pointer+1. If the pointer was QUEUE_DEPTH-1 or the next entry is invalid -> IDLE with done=1; else -> LOAD.
  - REPEAT: as NORMAL, but wraps to 0 and -> LOAD. mode is sampled here; if mode is no longer REPEAT -> IDLE with done=1. An all-invalid queue -> IDLE with done=1.
  - AUTO_INCR: pointer+1 modulo QUEUE_DEPTH, -> IDLE with done=1 (one entry per start).
- Throughput: one request per cycle in ACTIVE with rd_ready=1. First rd_en is asserted 2 cycles after start (IDLE->LOAD->ACTIVE).
- cur_entry tracks the pointer.

Decomposition:
- Shared package: loop_ctrl_t, dma_ld_header_t parametrised by LOOP_LEVEL, the mode localparams, and the state enum.
- Sub-module glb_loop_iter: one loop level holding the iteration counter, the stride accumulator, and carry in/out. It is instantiated LOOP_LEVEL times in a generate loop.

Test Plan:
- Entry0 {valid,start=0x100,L0 range4 stride8, other ranges 1}, NORMAL, start, rd_ready=1 -> addrs 0x100,0x108,0x110,0x118 on consecutive cycles, first 2 cycles after start; done 2 cycles after last accept.
- 2-D walk: L0 range3 stride8, L1 range2 stride0x40, start 0 -> 0x00,0x08,0x10,0x40,0x48,0x50.
- Backpressure: drop rd_ready for 3 cycles mid-stream -> rd_addr held, no address skipped or repeated; range-8 stream completes with exactly 8 accepts.
- Duty cycle: range 6, num_active_words=2, num_inactive_words=3 -> pattern 2 on, 3 off, 2 on, 3 off, 2 on, then NEXT (no trailing gap).
- Modes:
  - Entries 0,1 valid, 2 invalid. NORMAL -> entries 0,1 then done.
  - REPEAT -> 0,1,0,1... until mode is set to NORMAL, then done at the next entry boundary.
  - AUTO_INCR with three starts -> cur_entry 0,1,2, where entry 2 produces no requests but still pulses done.
- Reset mid-run: deassert reset_n during ACTIVE -> rd_en, busy, done and valid bits are 0 immediately. A start after reset with no header writes produces no requests and pulses done.

Source files
------------

// File: rtl/glb_ld_dma_addr_gen_pkg.sv
//==============================================================================
// Module : glb_ld_dma_addr_gen_pkg
// Brief  : Shared sizes, header types, run modes and FSM states for the GLB load DMA.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package glb_ld_dma_addr_gen_pkg;

   localparam int LOOP_LEVEL          = 4;
   localparam int QUEUE_DEPTH         = 4;
   localparam int GLB_ADDR_WIDTH      = 22;
   localparam int MAX_NUM_WORDS_WIDTH = 16;
   localparam int MAX_STRIDE_WIDTH    = 16;
   localparam int QIDX_WIDTH          = $clog2(QUEUE_DEPTH);
   localparam int HDR_WIDTH           = 1 + GLB_ADDR_WIDTH
                                      + LOOP_LEVEL * (MAX_NUM_WORDS_WIDTH + MAX_STRIDE_WIDTH)
                                      + 2 * MAX_NUM_WORDS_WIDTH;

   localparam logic [1:0] MODE_OFF       = 2'd0;
   localparam logic [1:0] MODE_NORMAL    = 2'd1;
   localparam logic [1:0] MODE_REPEAT    = 2'd2;
   localparam logic [1:0] MODE_AUTO_INCR = 2'd3;

   typedef struct packed {
      logic [MAX_NUM_WORDS_WIDTH-1:0] range;
      logic [MAX_STRIDE_WIDTH-1:0]    stride;
   } loop_ctrl_t;

   typedef struct packed {
      logic                                valid;
      logic [GLB_ADDR_WIDTH-1:0]           start_addr;
      loop_ctrl_t [LOOP_LEVEL-1:0]         iteration;
      logic [MAX_NUM_WORDS_WIDTH-1:0]      num_active_words;
      logic [MAX_NUM_WORDS_WIDTH-1:0]      num_inactive_words;
   } dma_ld_header_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_GAP    = 3'd3,
      ST_NEXT   = 3'd4
   } state_t;

   // A header produces requests only when valid and every loop level iterates at least once.
   function automatic logic hdr_runnable(input dma_ld_header_t h);
      logic ok;
      ok = h.valid;
      for (int i = 0; i < LOOP_LEVEL; i++) begin
         if (h.iteration[i].range == '0) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

`default_nettype wire

// File: rtl/glb_ld_dma_addr_gen_if.sv
//==============================================================================
// Module : glb_ld_dma_addr_gen_if
// Brief  : Control, header-write and read-request bundle of the GLB load DMA.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface glb_ld_dma_addr_gen_if;
   import glb_ld_dma_addr_gen_pkg::*;

   logic [1:0]                mode;
   logic                      start;
   logic                      hdr_wr_en;
   logic [QIDX_WIDTH-1:0]     hdr_wr_idx;
   logic [HDR_WIDTH-1:0]      hdr_wr_data;
   logic                      rd_ready;
   logic                      rd_en;
   logic [GLB_ADDR_WIDTH-1:0] rd_addr;
   logic                      busy;
   logic                      done;
   logic [QIDX_WIDTH-1:0]     cur_entry;

   modport master (
      output mode, start, hdr_wr_en, hdr_wr_idx, hdr_wr_data, rd_ready,
      input  rd_en, rd_addr, busy, done, cur_entry
   );

   modport slave (
      input  mode, start, hdr_wr_en, hdr_wr_idx, hdr_wr_data, rd_ready,
      output rd_en, rd_addr, busy, done, cur_entry
   );

endinterface

`default_nettype wire

// File: rtl/glb_ld_dma_addr_gen_loop_iter.sv
//==============================================================================
// Module : glb_loop_iter
// Brief  : One loop level: iteration counter, running stride offset, carry chain.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module glb_loop_iter
   import glb_ld_dma_addr_gen_pkg::*;
(
   input  wire logic                           clk,
   input  wire logic                           reset_n,
   input  wire logic                           i_clear,
   input  wire logic                           i_step,
   input  wire logic [MAX_NUM_WORDS_WIDTH-1:0] i_range,
   input  wire logic [MAX_STRIDE_WIDTH-1:0]    i_stride,
   output logic                                o_carry,
   output logic [GLB_ADDR_WIDTH-1:0]           o_offset
);

   logic [MAX_NUM_WORDS_WIDTH-1:0] r_itr;
   logic [GLB_ADDR_WIDTH-1:0]      r_offset;
   logic                           w_wrap;

   assign w_wrap   = (r_itr == i_range - MAX_NUM_WORDS_WIDTH'(1));
   assign o_carry  = i_step && w_wrap;
   assign o_offset = r_offset;

   // Offset tracks itr*stride by accumulation, so no multiplier is needed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_itr    <= '0;
         r_offset <= '0;
      end else if (i_clear) begin
         r_itr    <= '0;
         r_offset <= '0;
      end else if (i_step) begin
         if (w_wrap) begin
            r_itr    <= '0;
            r_offset <= '0;
         end else begin
            r_itr    <= r_itr + MAX_NUM_WORDS_WIDTH'(1);
            r_offset <= r_offset + GLB_ADDR_WIDTH'(i_stride);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/glb_ld_dma_addr_gen.sv
//==============================================================================
// Module : glb_ld_dma_addr_gen
// Brief  : Queued multi-level load-DMA read-address generator with duty cycling.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module glb_ld_dma_addr_gen
   import glb_ld_dma_addr_gen_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             reset_n,
   glb_ld_dma_addr_gen_if.slave  bus
);

   localparam int CW = MAX_NUM_WORDS_WIDTH + 1;

   state_t                    r_state, w_state_nxt;
   dma_ld_header_t            r_queue [QUEUE_DEPTH];
   dma_ld_header_t            r_hdr;
   dma_ld_header_t            w_cur;
   logic [QIDX_WIDTH-1:0]     r_ptr, w_ptr_nxt, w_ptr_inc;
   logic [1:0]                r_run_mode;
   logic [MAX_NUM_WORDS_WIDTH-1:0] r_word_cnt, r_gap_cnt;
   logic                      r_done, w_done_nxt;
   logic [LOOP_LEVEL:0]       w_step;
   logic [GLB_ADDR_WIDTH-1:0] w_off [LOOP_LEVEL];
   logic [GLB_ADDR_WIDTH-1:0] w_addr;
   logic                      w_rd_en, w_accept, w_last, w_gap_hit, w_gap_end;
   logic                      w_any_valid, w_ptr_last, w_nxt_invalid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) r_queue[i] <= '0;
      end else if (bus.hdr_wr_en) begin
         r_queue[bus.hdr_wr_idx] <= dma_ld_header_t'(bus.hdr_wr_data);
      end
   end

   always_comb begin
      w_any_valid = 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) w_any_valid = w_any_valid | r_queue[i].valid;
   end

   assign w_cur         = r_queue[r_ptr];
   assign w_ptr_inc     = r_ptr + QIDX_WIDTH'(1);
   assign w_ptr_last    = (r_ptr == QIDX_WIDTH'(QUEUE_DEPTH - 1));
   assign w_nxt_invalid = !r_queue[w_ptr_inc].valid;

   assign w_rd_en   = (r_state == ST_ACTIVE) && r_hdr.valid;
   assign w_accept  = w_rd_en && bus.rd_ready;
   assign w_step[0] = w_accept;
   assign w_last    = w_step[LOOP_LEVEL];
   assign w_gap_hit = (r_hdr.num_active_words != '0) && (r_hdr.num_inactive_words != '0)
                   && (({1'b0, r_word_cnt} + CW'(1)) == {1'b0, r_hdr.num_active_words});
   assign w_gap_end = (({1'b0, r_gap_cnt} + CW'(1)) == {1'b0, r_hdr.num_inactive_words});

   generate
      for (genvar lvl = 0; lvl < LOOP_LEVEL; lvl++) begin : g_loop
         glb_loop_iter u_iter (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_clear  (r_state == ST_LOAD),
            .i_step   (w_step[lvl]),
            .i_range  (r_hdr.iteration[lvl].range),
            .i_stride (r_hdr.iteration[lvl].stride),
            .o_carry  (w_step[lvl+1]),
            .o_offset (w_off[lvl])
         );
      end
   endgenerate

   always_comb begin
      w_addr = r_hdr.start_addr;
      for (int i = 0; i < LOOP_LEVEL; i++) w_addr = w_addr + w_off[i];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start && (bus.mode != MODE_OFF)) begin
               w_state_nxt = ST_LOAD;
               if (bus.mode != MODE_AUTO_INCR) w_ptr_nxt = '0;
            end
         end
         ST_LOAD:   w_state_nxt = hdr_runnable(w_cur) ? ST_ACTIVE : ST_NEXT;
         // Outermost wrap ends the entry even if a gap would also be due.
         ST_ACTIVE: begin
            if (w_accept) begin
               if (w_last)         w_state_nxt = ST_NEXT;
               else if (w_gap_hit) w_state_nxt = ST_GAP;
            end
         end
         ST_GAP:    if (w_gap_end) w_state_nxt = ST_ACTIVE;
         ST_NEXT: begin
            w_ptr_nxt = w_ptr_inc;
            if (r_run_mode == MODE_REPEAT) begin
               if ((bus.mode != MODE_REPEAT) || !w_any_valid) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_LOAD;
                  if (w_ptr_last || w_nxt_invalid) w_ptr_nxt = '0;
               end
            end else if ((r_run_mode == MODE_AUTO_INCR) || w_ptr_last || w_nxt_invalid) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_done     <= 1'b0;
         r_run_mode <= MODE_OFF;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_done  <= w_done_nxt;
         if ((r_state == ST_IDLE) && bus.start && (bus.mode != MODE_OFF)) r_run_mode <= bus.mode;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hdr      <= '0;
         r_word_cnt <= '0;
         r_gap_cnt  <= '0;
      end else begin
         if (r_state == ST_LOAD) begin
            r_hdr      <= w_cur;
            r_word_cnt <= '0;
         end else if (w_accept) begin
            r_word_cnt <= w_gap_hit ? '0 : r_word_cnt + MAX_NUM_WORDS_WIDTH'(1);
         end
         r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + MAX_NUM_WORDS_WIDTH'(1) : '0;
      end
   end

   assign bus.rd_en     = w_rd_en;
   assign bus.rd_addr   = w_addr;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.done      = r_done;
   assign bus.cur_entry = r_ptr;

endmodule

`default_nettype wire
